// File: rtl/reram_tiled_controller.sv
// Tiled ReRAM inference controller: buffers an input vector, then sweeps every
// column block and row tile of the crossbar, accumulating saturated partial sums.
module reram_tiled_controller #(
  parameter int IN_W      = 8,
  parameter int ADC_W     = 12,
  parameter int ACC_W     = 20,
  parameter int NUM_IN    = 784,
  parameter int NUM_OUT   = 256,
  parameter int XBAR_ROWS = 128,
  parameter int XBAR_COLS = 64,
  parameter int TIMEOUT   = 4096,
  localparam int NUM_TILES = (NUM_IN + XBAR_ROWS - 1) / XBAR_ROWS,
  localparam int NUM_BLK   = NUM_OUT / XBAR_COLS,
  localparam int ROW_W     = (XBAR_ROWS > 1) ? $clog2(XBAR_ROWS) : 1,
  localparam int TILE_W    = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
  localparam int BLK_W     = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1,
  localparam int COL_W     = (XBAR_COLS > 1) ? $clog2(XBAR_COLS) : 1,
  localparam int OUT_AW    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_relu_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  input  logic [IN_W-1:0]   i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [IN_W-1:0]   o_dac_data,
  output logic [ROW_W-1:0]  o_dac_row,
  output logic              o_dac_valid,
  output logic              o_xbar_start,
  output logic [TILE_W-1:0] o_xbar_tile,
  output logic [BLK_W-1:0]  o_xbar_blk,
  input  logic              i_xbar_done,
  output logic              o_adc_req,
  output logic [COL_W-1:0]  o_adc_col,
  input  logic [ADC_W-1:0]  i_adc_data,
  input  logic              i_adc_valid,
  output logic [ACC_W-1:0]  o_out_data,
  output logic [OUT_AW-1:0] o_out_addr,
  output logic              o_out_valid,
  input  logic              i_out_ready
);

  localparam int BUF_AW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int GIDX_W = $clog2(NUM_TILES * XBAR_ROWS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRIVE, S_EVAL, S_READ, S_EMIT, S_DONE, S_ERR
  } state_t;

  state_t r_state, w_next;

  logic [BUF_AW-1:0] r_loadCnt;
  logic [ROW_W-1:0]  r_row;
  logic [TILE_W-1:0] r_tile;
  logic [BLK_W-1:0]  r_blk;
  logic [COL_W-1:0]  r_col;
  logic [TMR_W-1:0]  r_timer;
  logic              r_reqPending;
  logic              r_relu;
  logic [IN_W-1:0]   r_buf [NUM_IN];
  logic [ACC_W-1:0]  r_acc [XBAR_COLS];

  logic              w_lastRow, w_lastCol, w_lastTile, w_lastBlk, w_lastLoad, w_timeout;
  logic              w_loadFire, w_adcFire, w_emitFire;
  logic [GIDX_W-1:0] w_gIdx;
  logic              w_padRow;
  logic [BUF_AW-1:0] w_bufIdx;
  logic [ACC_W:0]    w_adcExt, w_sum;
  logic [ACC_W-1:0]  w_sat, w_accNew, w_accCur;

  assign w_lastRow  = (r_row == ROW_W'(XBAR_ROWS - 1));
  assign w_lastCol  = (r_col == COL_W'(XBAR_COLS - 1));
  assign w_lastTile = (r_tile == TILE_W'(NUM_TILES - 1));
  assign w_lastBlk  = (r_blk == BLK_W'(NUM_BLK - 1));
  assign w_lastLoad = (r_loadCnt == BUF_AW'(NUM_IN - 1));
  assign w_timeout  = (r_timer == TMR_W'(TIMEOUT - 1));

  assign w_loadFire = (r_state == S_LOAD) && i_in_valid;
  assign w_adcFire  = (r_state == S_READ) && r_reqPending && i_adc_valid;
  assign w_emitFire = (r_state == S_EMIT) && i_out_ready;

  // Rows past the end of the input vector in the last tile are driven as zero.
  assign w_gIdx   = GIDX_W'(r_tile) * GIDX_W'(XBAR_ROWS) + GIDX_W'(r_row);
  assign w_padRow = (w_gIdx >= GIDX_W'(NUM_IN));
  assign w_bufIdx = BUF_AW'(w_gIdx);

  assign w_adcExt = {{(ACC_W + 1 - ADC_W){i_adc_data[ADC_W-1]}}, i_adc_data};
  assign w_accCur = r_acc[r_col];
  assign w_sum    = {w_accCur[ACC_W-1], w_accCur} + w_adcExt;
  assign w_sat    = (w_sum[ACC_W] != w_sum[ACC_W-1])
                    ? (w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                    : w_sum[ACC_W-1:0];
  assign w_accNew = (r_tile == '0) ? w_adcExt[ACC_W-1:0] : w_sat;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_error      = 1'b0;
    o_in_ready   = 1'b0;
    o_dac_data   = '0;
    o_dac_row    = '0;
    o_dac_valid  = 1'b0;
    o_xbar_start = 1'b0;
    o_xbar_tile  = r_tile;
    o_xbar_blk   = r_blk;
    o_adc_req    = 1'b0;
    o_adc_col    = '0;
    o_out_data   = '0;
    o_out_addr   = '0;
    o_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_LOAD;
      S_LOAD: begin
        o_busy     = 1'b1;
        o_in_ready = 1'b1;
        if (w_loadFire && w_lastLoad) w_next = S_DRIVE;
      end
      S_DRIVE: begin
        o_busy      = 1'b1;
        o_dac_valid = 1'b1;
        o_dac_row   = r_row;
        o_dac_data  = w_padRow ? '0 : r_buf[w_bufIdx];
        if (w_lastRow) w_next = S_EVAL;
      end
      S_EVAL: begin
        o_busy       = 1'b1;
        o_xbar_start = (r_timer == '0);
        if (i_xbar_done)    w_next = S_READ;
        else if (w_timeout) w_next = S_ERR;
      end
      S_READ: begin
        o_busy    = 1'b1;
        o_adc_req = !r_reqPending;
        o_adc_col = r_col;
        if (w_adcFire && w_lastCol) w_next = w_lastTile ? S_EMIT : S_DRIVE;
      end
      S_EMIT: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        o_out_data  = (r_relu && w_accCur[ACC_W-1]) ? '0 : w_accCur;
        o_out_addr  = OUT_AW'(r_blk) * OUT_AW'(XBAR_COLS) + OUT_AW'(r_col);
        if (w_emitFire && w_lastCol) w_next = w_lastBlk ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        o_error = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_loadCnt    <= '0;
      r_row        <= '0;
      r_tile       <= '0;
      r_blk        <= '0;
      r_col        <= '0;
      r_timer      <= '0;
      r_reqPending <= 1'b0;
      r_relu       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_loadCnt    <= '0;
          r_row        <= '0;
          r_tile       <= '0;
          r_blk        <= '0;
          r_col        <= '0;
          r_timer      <= '0;
          r_reqPending <= 1'b0;
          r_relu       <= i_relu_en;
        end
        S_LOAD: if (w_loadFire) r_loadCnt <= w_lastLoad ? '0 : r_loadCnt + BUF_AW'(1);
        S_DRIVE: begin
          r_row   <= w_lastRow ? '0 : r_row + ROW_W'(1);
          r_timer <= '0;
        end
        S_EVAL: r_timer <= r_timer + TMR_W'(1);
        // A request is outstanding from the cycle after adc_req until adc_valid.
        S_READ: begin
          if (!r_reqPending) begin
            r_reqPending <= 1'b1;
          end else if (i_adc_valid) begin
            r_reqPending <= 1'b0;
            r_col        <= w_lastCol ? '0 : r_col + COL_W'(1);
            if (w_lastCol && !w_lastTile) r_tile <= r_tile + TILE_W'(1);
          end
        end
        S_EMIT: if (w_emitFire) begin
          r_col <= w_lastCol ? '0 : r_col + COL_W'(1);
          if (w_lastCol && !w_lastBlk) begin
            r_blk  <= r_blk + BLK_W'(1);
            r_tile <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer and accumulators carry no reset: tile 0 overwrites every accumulator.
  always_ff @(posedge i_clk) begin
    if (w_loadFire) r_buf[r_loadCnt] <= i_in_data;
    if (w_adcFire)  r_acc[r_col]     <= w_accNew;
  end

endmodule

// File: tb/tb_reram_tiled_controller.sv
// Directed bench for reram_tiled_controller on a small 5-input, 2x2-tile configuration
// with behavioural crossbar/ADC responders.
module tb_reram_tiled_controller;

  localparam int IN_W      = 8;
  localparam int ADC_W     = 12;
  localparam int ACC_W     = 12;
  localparam int NUM_IN    = 5;
  localparam int NUM_OUT   = 4;
  localparam int XBAR_ROWS = 4;
  localparam int XBAR_COLS = 2;
  localparam int TIMEOUT   = 16;
  localparam int NUM_TILES = 2;
  localparam int NUM_BLK   = 2;
  localparam int MIN_LAT   = NUM_IN + NUM_BLK * (NUM_TILES * (XBAR_ROWS + 2 + 2 * XBAR_COLS) + XBAR_COLS);
  localparam int DAC_LEN   = NUM_BLK * NUM_TILES * XBAR_ROWS;

  logic             clk = 1'b0;
  logic             rst, start, reluEn, inValid, outReady;
  logic [IN_W-1:0]  inData;
  logic             xbarDone = 1'b0, adcValid = 1'b0;
  logic [ADC_W-1:0] adcData = '0;

  logic             busy, done, error, inReady, dacValid, xbarStart, adcReq, outValid;
  logic [IN_W-1:0]  dacData;
  logic [1:0]       dacRow;
  logic             xbarTile, xbarBlk, adcCol;
  logic [ACC_W-1:0] outData;
  logic [1:0]       outAddr;

  always #5 clk = ~clk;

  reram_tiled_controller #(
    .IN_W(IN_W), .ADC_W(ADC_W), .ACC_W(ACC_W), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT),
    .XBAR_ROWS(XBAR_ROWS), .XBAR_COLS(XBAR_COLS), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_relu_en(reluEn),
    .o_busy(busy), .o_done(done), .o_error(error),
    .i_in_data(inData), .i_in_valid(inValid), .o_in_ready(inReady),
    .o_dac_data(dacData), .o_dac_row(dacRow), .o_dac_valid(dacValid),
    .o_xbar_start(xbarStart), .o_xbar_tile(xbarTile), .o_xbar_blk(xbarBlk), .i_xbar_done(xbarDone),
    .o_adc_req(adcReq), .o_adc_col(adcCol), .i_adc_data(adcData), .i_adc_valid(adcValid),
    .o_out_data(outData), .o_out_addr(outAddr), .o_out_valid(outValid), .i_out_ready(outReady)
  );

  int testsRun = 0, testsFailed = 0;
  int cycleCnt = 0, startCycle = 0, doneCycle = 0;
  int doneCount = 0, errorCount = 0;
  logic xbarEnable = 1'b1, prevStart = 1'b0, prevReq = 1'b0;
  logic signed [ADC_W-1:0] adcTile0 = '0, adcTile1 = '0;
  logic [IN_W-1:0]  dacQ[$];
  logic [ACC_W-1:0] outDataQ[$];
  logic [1:0]       outAddrQ[$];
  logic [IN_W-1:0]  expDac[8];

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Crossbar and ADC answer one cycle after their request; loggers watch the DUT mid-cycle.
  always @(negedge clk) begin
    xbarDone  = xbarEnable && prevStart;
    prevStart = xbarStart;
    adcValid  = prevReq;
    adcData   = (xbarTile == 1'b0) ? adcTile0 : adcTile1;
    prevReq   = adcReq;
    if (dacValid) dacQ.push_back(dacData);
    if (outValid && outReady) begin
      outDataQ.push_back(outData);
      outAddrQ.push_back(outAddr);
    end
    if (done) begin
      doneCount++;
      doneCycle = cycleCnt;
    end
    if (error) errorCount++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {busy, done, error, inReady, dacValid, xbarStart, adcReq, outValid}, 0);
    checkOutput({tag, "_fields"}, {dacData, dacRow, xbarTile, xbarBlk, adcCol, outAddr}, 0);
    checkOutput({tag, "_out_data"}, outData, 0);
  endtask

  task automatic clearLogs();
    dacQ.delete();
    outDataQ.delete();
    outAddrQ.delete();
  endtask

  // Pulse start with the requested ReLU setting, then stream inputs 1..NUM_IN.
  task automatic applyStimulus(input logic relu, input bit randomValid);
    int loaded = 0;
    int guard = 0;
    bit acceptNow;
    reluEn = relu;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    reluEn = 1'b0;
    startCycle = cycleCnt;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("in_ready_after_start", inReady, 1);
    while (loaded < NUM_IN && guard < 200) begin
      inData    = IN_W'(loaded + 1);
      inValid   = randomValid ? 1'($urandom_range(0, 1)) : 1'b1;
      acceptNow = inValid && inReady;
      tick();
      if (acceptNow) loaded++;
      guard++;
    end
    inValid = 1'b0;
    checkOutput("load_words", loaded, NUM_IN);
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    int d0 = doneCount;
    int e0 = errorCount;
    while (doneCount == d0 && errorCount == e0 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput({tag, "_finished"}, doneCount - d0, 1);
  endtask

  task automatic checkRun(input string tag, input logic signed [31:0] expVal);
    checkOutput({tag, "_out_count"}, outDataQ.size(), NUM_OUT);
    for (int i = 0; i < NUM_OUT; i++) begin
      if (i < outDataQ.size()) begin
        checkOutput({tag, "_data"}, $signed(outDataQ[i]), expVal);
        checkOutput({tag, "_addr"}, outAddrQ[i], i);
      end
    end
    checkOutput({tag, "_dac_count"}, dacQ.size(), DAC_LEN);
    for (int i = 0; i < DAC_LEN; i++) begin
      if (i < dacQ.size()) checkOutput({tag, "_dac"}, dacQ[i], expDac[i % 8]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int d0;
    int stable;
    expDac   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0};
    rst      = 1'b1;
    start    = 1'b0;
    reluEn   = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    outReady = 1'b1;
    tick(3);
    checkAllZero("reset");
    rst = 1'b0;
    tick();

    // Basic flow and accumulation: 100 + (-30) in every column.
    adcTile0 = 12'sd100;
    adcTile1 = -12'sd30;
    clearLogs();
    applyStimulus(1'b0, 1'b0);
    waitDone("accum");
    checkOutput("latency", doneCycle - startCycle, MIN_LAT);
    checkOutput("busy_at_done", busy, 0);
    checkRun("accum", 70);
    tick();
    checkOutput("done_one_cycle", done, 0);
    checkOutput("done_count", doneCount, 1);
    checkOutput("no_error", errorCount, 0);

    // Same run with gapped input handshakes.
    clearLogs();
    applyStimulus(1'b0, 1'b1);
    waitDone("randvalid");
    checkRun("randvalid", 70);

    // Positive and negative saturation at ACC_W = 12.
    adcTile0 = 12'sd2047;
    adcTile1 = 12'sd2047;
    clearLogs();
    applyStimulus(1'b0, 1'b0);
    waitDone("sat_pos");
    checkRun("sat_pos", 2047);

    adcTile0 = -12'sd2048;
    adcTile1 = -12'sd2048;
    clearLogs();
    applyStimulus(1'b0, 1'b0);
    waitDone("sat_neg");
    checkRun("sat_neg", -2048);

    // Negative result with and without ReLU (relu_en is dropped right after start).
    adcTile0 = -12'sd5;
    adcTile1 = 12'sd0;
    clearLogs();
    applyStimulus(1'b0, 1'b0);
    waitDone("neg_norelu");
    checkRun("neg_norelu", -5);

    clearLogs();
    applyStimulus(1'b1, 1'b0);
    waitDone("neg_relu");
    checkRun("neg_relu", 0);

    // Backpressure: hold the second output for 10 cycles.
    adcTile0 = 12'sd100;
    adcTile1 = -12'sd30;
    outReady = 1'b0;
    clearLogs();
    applyStimulus(1'b0, 1'b0);
    n = 0;
    while (!outValid && n < 500) begin
      tick();
      n++;
    end
    checkOutput("bp_reach_emit", outValid, 1);
    checkOutput("bp_first_addr", outAddr, 0);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    stable = 0;
    repeat (10) begin
      if (outValid && outAddr == 2'd1 && $signed(outData) == 70) stable++;
      tick();
    end
    checkOutput("bp_hold_stable", stable, 10);
    checkOutput("bp_nothing_lost_yet", outDataQ.size(), 1);
    outReady = 1'b1;
    waitDone("bp");
    checkRun("bp", 70);

    // Timeout: crossbar never answers.
    xbarEnable = 1'b0;
    clearLogs();
    applyStimulus(1'b0, 1'b0);
    n = 0;
    while (!xbarStart && n < 200) begin
      tick();
      n++;
    end
    checkOutput("to_xbar_start_seen", xbarStart, 1);
    n = 0;
    while (!error && n < 100) begin
      tick();
      n++;
    end
    checkOutput("to_error_delay", n, TIMEOUT);
    checkOutput("to_busy_low", busy, 0);
    tick();
    checkOutput("to_error_one_cycle", error, 0);
    checkOutput("to_error_count", errorCount, 1);
    checkOutput("to_no_outputs", outDataQ.size(), 0);
    xbarEnable = 1'b1;
    tick(3);

    // Reset asserted while reading the ADC.
    clearLogs();
    d0 = doneCount;
    applyStimulus(1'b0, 1'b0);
    n = 0;
    while (!adcReq && n < 200) begin
      tick();
      n++;
    end
    checkOutput("rst_reach_read", adcReq, 1);
    rst = 1'b1;
    tick();
    checkAllZero("rst_mid");
    rst = 1'b0;
    tick(80);
    checkOutput("rst_no_done", doneCount - d0, 0);
    checkOutput("rst_idle_busy", busy, 0);
    checkOutput("rst_no_outputs", outDataQ.size(), 0);

    // Start pulsed during DRIVE is ignored.
    clearLogs();
    d0 = doneCount;
    applyStimulus(1'b0, 1'b0);
    n = 0;
    while (!dacValid && n < 200) begin
      tick();
      n++;
    end
    checkOutput("si_reach_drive", dacValid, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone("si");
    tick(80);
    checkOutput("si_single_done", doneCount - d0, 1);
    checkOutput("si_idle", busy, 0);
    checkRun("si", 70);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
